dispatch_rs_allocator: RTL
==========================

// Module: dispatch_rs_allocator
// PURPOSE
//  Multi-lane reservation-station (RS) entry allocator between dispatch and the per-FU schedulers.
//  Each cycle it grants up to DISP_WIDTH in-order dispatch lanes a free RS entry in their target FU,
//  tracks per-FU occupancy, and frees entries on scheduler issue.
//  Replaces the single-lane rs_entry_idx/rs_full handshake.
//  Adds multi-lane dispatch, per-FU counts, an almost-full threshold and flush.
// PARAMETERS
//  NUM_FUS      4   number of functional units (one RS bank each)
//  RS_ENTRIES   8   entries per RS bank (power of 2, >=2)
//  DISP_WIDTH   2   dispatch lanes per cycle (1..4)
//  AFULL_THRESH 6   rs_afull[f] asserts when count[f] >= AFULL_THRESH
//  FU_W = $clog2(NUM_FUS), ENT_W = $clog2(RS_ENTRIES), CNT_W = $clog2(RS_ENTRIES+1) (localparams)
// PORTS
//  clk            in   1                  core clock
//  rst_n          in   1                  synchronous active-low reset
//  flush          in   1                  pipeline flush: free every entry
//  lane_valid     in   DISP_WIDTH         lane i holds a uop to dispatch
//  lane_fu        in   DISP_WIDTH*FU_W    target FU of lane i
//  lane_ready     out  DISP_WIDTH         lane i granted this cycle
//  lane_entry     out  DISP_WIDTH*ENT_W   RS entry index granted to lane i
//  rel_valid      in   NUM_FUS            scheduler f issued/freed an entry
//  rel_entry      in   NUM_FUS*ENT_W      entry freed in bank f
//  rs_full        out  NUM_FUS            bank f has zero free entries (registered view)
//  rs_afull       out  NUM_FUS            count[f] >= AFULL_THRESH
//  rs_count       out  NUM_FUS*CNT_W      occupied entries in bank f
// BEHAVIOUR
//  State: busy[f][e] bitmap, count[f]. Reset (rst_n=0 at posedge): busy=0, count=0.
//   Outputs after reset: rs_full=0, rs_afull=0, rs_count=0, lane_ready=0 (flush/reset cycle).
//  Grant (combinational, from current busy): lanes are scanned 0..DISP_WIDTH-1 in order.
//   Lane i is granted iff lane_valid[i], every lane j<i is granted or invalid,
//   and bank lane_fu[i] still has a free entry after removing entries granted to lanes j<i.
//   First ungranted valid lane blocks all higher lanes (in-order, no bypass).
//   lane_ready[i]=0 for invalid lanes. lane_entry[i] = lowest-index free entry not taken by lanes j<i.
//   Two lanes to the same bank get distinct entries, lower lane gets lower index.
//   lane_entry is don't-care when lane_ready[i]=0; drive 0.
//  Handshake: a uop dispatches when lane_valid&lane_ready; busy bit sets at next posedge.
//   Dispatch must hold lane_valid/lane_fu stable only within the cycle; no multicycle contract.
//  Release: rel_valid[f] clears busy[f][rel_entry[f]] at next posedge.
//   A freed entry is NOT grantable in the same cycle (no release->alloc bypass).
//   Release of a non-busy entry: ignored, count unchanged (assertion flags it in sim).
//  Count: count[f] <= count[f] + grants_to_f - (valid release to f); never exceeds RS_ENTRIES.
//   rs_count = count; rs_full = (count==RS_ENTRIES); rs_afull = (count>=AFULL_THRESH).
//   Simultaneous grant+release in bank f: both applied; full bank with a release stays full for that cycle.
//  Flush: when flush=1, lane_ready=0 that cycle, releases ignored.
//   busy=0 and count=0 at next posedge. Reset has priority over flush.
//  lane_fu >= NUM_FUS: lane treated as not grantable (blocks higher lanes).
// TESTING
//  1 Reset: rst_n=0 2 cycles, lane_valid=11 -> lane_ready=00, rs_count all 0, rs_full=0.
//  2 Same bank: lanes 0,1 fu=2, empty -> ready=11, entries 0,1; next cycle rs_count[2]=2.
//  3 Fill: keep dispatching fu=1 until 8 -> rs_full[1]=1.
//     Next lane_valid=01 fu=1 -> ready=00; rs_afull[1] set once count reached 6.
//  4 In-order block: bank 0 full, lane0 fu=0, lane1 fu=3 -> ready=00; lane1 never bypasses.
//  5 Release no-bypass: bank 0 full, rel_valid[0]=1 entry 5 with lane0 fu=0 -> ready=0 this cycle.
//     Next cycle ready=1, entry=5, count back to 8.
//  6 Flush mid-fill: counts {3,8,0,1}, flush=1 with lane_valid=11 -> ready=00.
//     Next cycle all counts 0, rs_full=0.
//     Reset asserted during the same flush cycle -> identical result.

Source files
------------

// File: rtl/dispatch_rs_allocator.sv
`default_nettype none
// ============================================================================
//  Module   : dispatch_rs_allocator
//  Purpose  : Multi-lane reservation-station entry allocator. Grants in-order
//             dispatch lanes a free entry in their target FU bank, tracks
//             per-bank occupancy, frees entries on scheduler issue, and
//             clears all banks on flush.
//  Revision : 1.0  initial release
// ============================================================================
module dispatch_rs_allocator #(
    parameter  int NUM_FUS      = 4,
    parameter  int RS_ENTRIES   = 8,
    parameter  int DISP_WIDTH   = 2,
    parameter  int AFULL_THRESH = 6,
    localparam int FU_W         = $clog2(NUM_FUS),
    localparam int ENT_W        = $clog2(RS_ENTRIES),
    localparam int CNT_W        = $clog2(RS_ENTRIES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic [DISP_WIDTH-1:0]       lane_valid_i,
    input  logic [DISP_WIDTH*FU_W-1:0]  lane_fu_i,
    output logic [DISP_WIDTH-1:0]       lane_ready_o,
    output logic [DISP_WIDTH*ENT_W-1:0] lane_entry_o,
    input  logic [NUM_FUS-1:0]          rel_valid_i,
    input  logic [NUM_FUS*ENT_W-1:0]    rel_entry_i,
    output logic [NUM_FUS-1:0]          rs_full_o,
    output logic [NUM_FUS-1:0]          rs_afull_o,
    output logic [NUM_FUS*CNT_W-1:0]    rs_count_o
);

    // Occupancy state
    logic [NUM_FUS-1:0][RS_ENTRIES-1:0] busy_q, busy_d;
    logic [NUM_FUS-1:0][CNT_W-1:0]      count_q, count_d;

    // Grant scan working state
    logic [NUM_FUS-1:0][RS_ENTRIES-1:0] w_taken;
    logic [NUM_FUS-1:0][CNT_W-1:0]      w_grant_cnt;
    logic                               w_blocked;
    logic                               w_found;
    logic [FU_W-1:0]                    w_fu;
    logic [ENT_W-1:0]                   w_sel;
    logic [ENT_W-1:0]                   w_rel_e;
    logic                               w_rel_ok;

    // In-order lane scan: each lane takes the lowest entry still free after
    // lower lanes; the first valid lane that cannot be served stops the scan.
    always_comb begin
        w_taken      = busy_q;
        w_grant_cnt  = '0;
        w_blocked    = !rst_n || flush_i;
        w_found      = 1'b0;
        w_fu         = '0;
        w_sel        = '0;
        lane_ready_o = '0;
        lane_entry_o = '0;
        for (int i = 0; i < DISP_WIDTH; i++) begin
            w_fu    = lane_fu_i[i*FU_W +: FU_W];
            w_found = 1'b0;
            w_sel   = '0;
            if (lane_valid_i[i] && !w_blocked) begin
                if (int'(w_fu) < NUM_FUS) begin
                    // Descending scan so the last hit is the lowest free index
                    for (int e = RS_ENTRIES - 1; e >= 0; e--) begin
                        if (!w_taken[w_fu][e]) begin
                            w_found = 1'b1;
                            w_sel   = ENT_W'(e);
                        end
                    end
                end
                if (w_found) begin
                    lane_ready_o[i]                  = 1'b1;
                    lane_entry_o[i*ENT_W +: ENT_W]   = w_sel;
                    w_taken[w_fu][w_sel]             = 1'b1;
                    w_grant_cnt[w_fu]                = w_grant_cnt[w_fu] + CNT_W'(1);
                end else begin
                    w_blocked = 1'b1;
                end
            end
        end
    end

    // Next occupancy: grants set bits, releases of busy entries clear them.
    // Releases act on busy_q only, so a freed entry is never re-granted in
    // the same cycle.
    always_comb begin
        busy_d   = w_taken;
        count_d  = count_q;
        w_rel_e  = '0;
        w_rel_ok = 1'b0;
        if (flush_i) begin
            busy_d  = '0;
            count_d = '0;
        end else begin
            for (int f = 0; f < NUM_FUS; f++) begin
                w_rel_e  = rel_entry_i[f*ENT_W +: ENT_W];
                w_rel_ok = rel_valid_i[f] && busy_q[f][w_rel_e];
                if (w_rel_ok) begin
                    busy_d[f][w_rel_e] = 1'b0;
                end
                count_d[f] = count_q[f] + w_grant_cnt[f] - CNT_W'(w_rel_ok);
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    generate
        for (genvar f = 0; f < NUM_FUS; f++) begin : g_bank
            assign rs_count_o[f*CNT_W +: CNT_W] = count_q[f];
            assign rs_full_o[f]  = (count_q[f] == CNT_W'(RS_ENTRIES));
            assign rs_afull_o[f] = (count_q[f] >= CNT_W'(AFULL_THRESH));

            // A scheduler must only free entries it actually holds
            a_rel_busy : assert property (@(posedge clk) disable iff (!rst_n)
                (rel_valid_i[f] && !flush_i) |-> busy_q[f][rel_entry_i[f*ENT_W +: ENT_W]]);
        end
    endgenerate

endmodule
`default_nettype wire
